// File: rtl/cypress_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cypress_pkg                                               |
// | Description : Shared types and constants for the Cypress FX2 slave-FIFO |
// |               reader and writer: FSM state encoding and FIFOADR        |
// |               endpoint-select codes.                                    |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package cypress_pkg;

  // Reader state machine encoding.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    LO      = 3'd2,
    WAIT_HI = 3'd3,
    HI      = 3'd4,
    GAP     = 3'd5
  } rx_state_t;

  // FIFOADR endpoint-select codes (same for reader and writer).
  localparam logic [1:0] FIFOADR_EP2 = 2'b00;
  localparam logic [1:0] FIFOADR_EP4 = 2'b01;
  localparam logic [1:0] FIFOADR_EP6 = 2'b10;
  localparam logic [1:0] FIFOADR_EP8 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cypress_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cypress_rx                                                |
// | Description : Reader for the FX2 synchronous slave FIFO (host->FPGA OUT |
// |               endpoint). Drains 16-bit half-words from FD and packs   |
// |               each pair, low half first, into one 32-bit word offered  |
// |               on a valid/ready source port.                            |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
// | Ports                                                                   |
// |   ifclk         in   interface clock, all logic on posedge              |
// |   reset         in   synchronous, active-high                           |
// |   flag_ne       in   FIFO not-empty flag, active-high                   |
// |   fd_in         in   16-bit FX2 data bus                                |
// |   slrd          out  read strobe, active-low, registered                |
// |   sloe          out  FD output enable, active-low, registered           |
// |   fifoadr       out  endpoint select, constant EP_ADDR                  |
// |   source_data   out  packed word {second half, first half}              |
// |   source_valid  out  source_data valid, held until accepted             |
// |   source_ready  in   consumer accept                                    |
// |   rx_count      out  words delivered, wraps modulo 2^16                 |
// +------------------------------------------------------------------------+
module cypress_rx
  import cypress_pkg::*;
#(
  parameter logic [1:0] EP_ADDR  = FIFOADR_EP2,
  parameter int         FLAG_LAT = 2
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        flag_ne,
  input  logic [15:0] fd_in,
  output logic        slrd,
  output logic        sloe,
  output logic [1:0]  fifoadr,
  output logic [31:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic [15:0] rx_count
);

  localparam logic [2:0] LAT = 3'(FLAG_LAT);

  rx_state_t   state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] lo_reg, lo_n;
  logic        slrd_n, sloe_n, valid_n;
  logic [31:0] data_n;
  logic [15:0] count_n;

  assign fifoadr = EP_ADDR;

  always_ff @(posedge ifclk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      lo_reg       <= 16'd0;
      slrd         <= 1'b1;
      sloe         <= 1'b1;
      source_data  <= 32'd0;
      source_valid <= 1'b0;
      rx_count     <= 16'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lo_reg       <= lo_n;
      slrd         <= slrd_n;
      sloe         <= sloe_n;
      source_data  <= data_n;
      source_valid <= valid_n;
      rx_count     <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lo_n    = lo_reg;
    slrd_n  = 1'b1;              // strobe is a single-cycle pulse
    sloe_n  = sloe;
    data_n  = source_data;
    valid_n = source_valid;
    count_n = rx_count;

    // Acceptance; a load in HI on the same edge overrides the clear below.
    if (source_valid && source_ready) begin
      valid_n = 1'b0;
      count_n = rx_count + 16'd1;
    end

    case (state)
      IDLE: begin
        sloe_n = 1'b1;
        if (flag_ne) begin
          sloe_n  = 1'b0;
          state_n = CHECK;
        end
      end

      // A pair is only started when the output register will be free by
      // the time the high half lands, so HI never overwrites a pending word.
      CHECK: begin
        if (flag_ne && (!source_valid || source_ready)) begin
          slrd_n  = 1'b0;
          state_n = LO;
        end else if (!flag_ne) begin
          sloe_n  = 1'b1;
          state_n = IDLE;
        end
      end

      LO: begin
        lo_n    = fd_in;
        cnt_n   = LAT;
        state_n = WAIT_HI;
      end

      // Once the low half is taken the pair must complete: sloe stays low
      // and we wait on flag_ne indefinitely.
      WAIT_HI: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else if (flag_ne) begin
          slrd_n  = 1'b0;
          state_n = HI;
        end
      end

      HI: begin
        data_n  = {fd_in, lo_reg};
        valid_n = 1'b1;
        cnt_n   = LAT;
        state_n = GAP;
      end

      GAP: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else begin
          state_n = CHECK;
        end
      end

      default: begin
        sloe_n  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cypress_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_cypress_rx                                             |
// | Description : Directed bench for cypress_rx with an FX2 FIFO model and  |
// |               a scoreboard of expected packed words.                    |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_cypress_rx;

  localparam int FLAG_LAT = 2;

  logic        ifclk = 1'b0;
  logic        reset;
  logic        flag_ne;
  logic [15:0] fd_in;
  logic        slrd;
  logic        sloe;
  logic [1:0]  fifoadr;
  logic [31:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic [15:0] rx_count;

  always #5 ifclk = ~ifclk;

  cypress_rx #(
    .EP_ADDR  (2'b00),
    .FLAG_LAT (FLAG_LAT)
  ) dut (
    .ifclk        (ifclk),
    .reset        (reset),
    .flag_ne      (flag_ne),
    .fd_in        (fd_in),
    .slrd         (slrd),
    .sloe         (sloe),
    .fifoadr      (fifoadr),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .rx_count     (rx_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          flag_rise_cyc = 0;
  int          valid_rise_cyc = 0;
  logic [15:0] fx_q[$];          // FX2 FIFO contents, head = fx_q[0]
  logic [31:0] exp_q[$];         // expected packed words, in order
  logic [15:0] exp_count = 16'd0;
  logic        flag_en = 1'b1;
  logic        strobe_prev = 1'b0;
  logic        prev_hold = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_flag = 1'b0;
  logic [31:0] prev_data = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: observe/model at negedge, return at posedge+1 so the
  // caller drives inputs well away from the active edge.
  task automatic tick();
    @(negedge ifclk);
    cyc++;
    // The FX2 advances its FIFO on every edge that saw slrd low.
    if (strobe_prev && fx_q.size() != 0) void'(fx_q.pop_front());

    chk("b2b_slrd", 32'(!(strobe_prev && !slrd)), 32'd1);
    chk("slrd_sloe", 32'(slrd || !sloe), 32'd1);
    chk("fifoadr", 32'(fifoadr), 32'd0);
    if (!slrd) begin
      strobes++;
      chk("read_nonempty", 32'(fx_q.size() != 0), 32'd1);
    end

    if (!reset) begin
      if (prev_hold) begin
        chk("hold_data", source_data, prev_data);
        chk("hold_valid", 32'(source_valid), 32'd1);
      end
      if (source_valid && source_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_word observed=%h expected=none", source_data);
        end
        if (exp_q.size() != 0) chk("data", source_data, exp_q.pop_front());
        chk("rx_count", 32'(rx_count), 32'(exp_count));
        exp_count++;
      end
      prev_hold = source_valid && !source_ready;
    end else begin
      exp_count = 16'd0;
      prev_hold = 1'b0;
    end
    prev_data = source_data;
    if (source_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = source_valid;

    fd_in   = (fx_q.size() != 0) ? fx_q[0] : 16'hDEAD;
    flag_ne = flag_en && (fx_q.size() != 0);
    if (flag_ne && !prev_flag) flag_rise_cyc = cyc;
    prev_flag   = flag_ne;
    strobe_prev = !slrd;
    @(posedge ifclk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(strobes >= target), 32'd1);
  endtask

  initial begin
    int s0;
    int n;
    reset        = 1'b1;
    flag_ne      = 1'b0;
    fd_in        = 16'd0;
    source_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset values
    chk("rst_slrd", 32'(slrd), 32'd1);
    chk("rst_sloe", 32'(sloe), 32'd1);
    chk("rst_valid", 32'(source_valid), 32'd0);
    chk("rst_data", source_data, 32'd0);
    chk("rst_count", 32'(rx_count), 32'd0);

    // 1: single pair, ready high, latency from first flag_ne sample
    source_ready = 1'b1;
    fx_q.push_back(16'h1234);
    fx_q.push_back(16'hABCD);
    exp_q.push_back(32'hABCD_1234);
    wait_drain("t1_drain", 100);
    tick();
    chk("t1_latency", 32'(valid_rise_cyc - flag_rise_cyc), 32'(FLAG_LAT + 5));
    chk("t1_count", 32'(rx_count), 32'd1);

    // 2: backpressure holds the word and blocks further reads
    source_ready = 1'b0;
    fx_q.push_back(16'h0001);
    fx_q.push_back(16'h0002);
    fx_q.push_back(16'h0003);
    fx_q.push_back(16'h0004);
    exp_q.push_back(32'h0002_0001);
    exp_q.push_back(32'h0004_0003);
    n = 0;
    while (!source_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t2_valid_timeout", 32'(source_valid), 32'd1);
    s0 = strobes;
    repeat (20) tick();
    chk("t2_stall_strobes", 32'(strobes - s0), 32'd0);
    chk("t2_stall_data", source_data, 32'h0002_0001);
    source_ready = 1'b1;
    wait_drain("t2_drain", 200);
    tick();
    chk("t2_count", 32'(rx_count), 32'd3);

    // 3: FIFO empties between halves; pair waits with sloe low
    fx_q.push_back(16'h5555);
    exp_q.push_back(32'h6666_5555);
    s0 = strobes;
    wait_strobes("t3_lo_timeout", s0 + 1, 100);
    s0 = strobes;
    repeat (10) begin
      tick();
      chk("t3_sloe_held", 32'(sloe), 32'd0);
    end
    chk("t3_no_strobe", 32'(strobes - s0), 32'd0);
    fx_q.push_back(16'h6666);
    wait_drain("t3_drain", 100);

    // 4: reset while waiting for the high half discards the low half
    fx_q.push_back(16'h7777);
    s0 = strobes;
    wait_strobes("t4_lo_timeout", s0 + 1, 100);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_slrd", 32'(slrd), 32'd1);
    chk("t4_sloe", 32'(sloe), 32'd1);
    chk("t4_valid", 32'(source_valid), 32'd0);
    chk("t4_count", 32'(rx_count), 32'd0);
    fx_q.push_back(16'h8888);
    fx_q.push_back(16'h9999);
    exp_q.push_back(32'h9999_8888);
    wait_drain("t4_drain", 100);
    tick();
    chk("t4_count_after", 32'(rx_count), 32'd1);

    // 5: ramp stream with random ready and flag gaps
    for (int k = 0; k < 150; k++) begin
      fx_q.push_back(16'(16'h0100 + 2 * k));
      fx_q.push_back(16'(16'h0101 + 2 * k));
      exp_q.push_back({16'(16'h0101 + 2 * k), 16'(16'h0100 + 2 * k)});
    end
    n = 0;
    while (exp_q.size() != 0 && n < 8000) begin
      source_ready = ($urandom_range(0, 3) != 0);
      flag_en      = ($urandom_range(0, 7) != 0);
      tick();
      n++;
    end
    flag_en      = 1'b1;
    source_ready = 1'b1;
    chk("t5_drain", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
    chk("t5_fifo_empty", 32'(fx_q.size()), 32'd0);
    chk("t5_count", 32'(rx_count), 32'd151);
    chk("t5_idle_valid", 32'(source_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
